// File: rtl/regmap_pkg.sv
// Shared types and helpers for the I2C register map.
package regmap_pkg;

   typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_t;

   localparam int REG_W = 8;
   localparam logic [REG_W-1:0] RD_FILL = 8'hFF;

   // Wraps at the end of the map; an out-of-range pointer also returns to 0.
   function automatic logic [7:0] ptr_inc(input logic [7:0] p, input logic [7:0] num_regs);
      return (p >= num_regs - 8'd1) ? 8'd0 : p + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_reg_map.sv
// Register map behind the I2C peripheral: pointer byte, auto-increment writes/reads.
// Optional REGMAP_STATUS_SNAPSHOT_EN: capture status_in at read start for coherent multi-byte reads.
module i2c_reg_map
   import regmap_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int RO_BASE  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              txn_start,
   input  logic                              txn_write,
   input  logic                              txn_stop,
   input  logic [7:0]                        rx_data,
   input  logic                              rx_valid,
   input  logic                              tx_taken,
   output logic [7:0]                        tx_data,
   output logic [8*RO_BASE-1:0]              ctrl_regs,
   input  logic [8*(NUM_REGS-RO_BASE)-1:0]   status_in,
   output logic                              wr_strobe,
   output logic [7:0]                        wr_index,
   output logic                              busy
);

   localparam int          NUM_RO = NUM_REGS - RO_BASE;
   localparam logic [7:0]  NREGS8 = 8'(NUM_REGS);
   localparam logic [7:0]  RO8    = 8'(RO_BASE);

   state_t                          state, state_nxt;
   logic [7:0]                      ptr, ptr_nxt;
   logic [RO_BASE-1:0][REG_W-1:0]   ctrl_q;
   logic [NUM_RO-1:0][REG_W-1:0]    stat_src;
   logic                            wr_en;
   logic                            tx_load;
   logic [REG_W-1:0]                rd_val;

`ifdef REGMAP_STATUS_SNAPSHOT_EN
   logic [NUM_RO-1:0][REG_W-1:0] shadow;

   always_ff @(posedge clk) begin
      if (rst)
         shadow <= '0;
      else if (txn_start && !txn_write)
         shadow <= status_in;
   end

   // The first byte is loaded on the same edge the shadow captures, so use the live value then.
   assign stat_src = (txn_start && !txn_write) ? status_in : shadow;
`else
   assign stat_src = status_in;
`endif

   assign ctrl_regs = ctrl_q;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      wr_en     = 1'b0;
      tx_load   = 1'b0;
      if (txn_start) begin
         // Start wins over any same-cycle byte or take.
         state_nxt = txn_write ? PTR : RDATA;
         tx_load   = !txn_write;
      end else begin
         case (state)
            PTR: if (rx_valid) begin
               ptr_nxt   = rx_data;
               state_nxt = WDATA;
            end
            WDATA: if (rx_valid) begin
               wr_en   = (ptr < RO8);
               ptr_nxt = ptr_inc(ptr, NREGS8);
            end
            RDATA: if (tx_taken) begin
               ptr_nxt = ptr_inc(ptr, NREGS8);
               tx_load = !txn_stop;
            end
            default: ;
         endcase
         if (txn_stop)
            state_nxt = IDLE;
      end
   end

   // Read mux on the post-update pointer so tx_data is ready one cycle after a take.
   always_comb begin
      rd_val = RD_FILL;
      for (int i = 0; i < RO_BASE; i++)
         if (ptr_nxt == 8'(i)) rd_val = ctrl_q[i];
      for (int i = 0; i < NUM_RO; i++)
         if (ptr_nxt == 8'(RO_BASE + i)) rd_val = stat_src[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         ctrl_q    <= '0;
         tx_data   <= '0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         wr_strobe <= wr_en;
         if (wr_en) begin
            wr_index <= ptr;
            for (int i = 0; i < RO_BASE; i++)
               if (ptr == 8'(i)) ctrl_q[i] <= rx_data;
         end
         if (tx_load)
            tx_data <= rd_val;
      end
   end

endmodule

// File: tb/tb_i2c_reg_map.sv
// Self-checking bench for i2c_reg_map: directed scenarios plus random transactions vs a byte-level model.
module tb_i2c_reg_map;

   localparam int NR = 16;
   localparam int RB = 8;
   localparam int NS = NR - RB;

   logic              clk = 0, rst = 1;
   logic              txn_start = 0, txn_write = 0, txn_stop = 0;
   logic              rx_valid = 0, tx_taken = 0;
   logic [7:0]        rx_data = 0;
   logic [7:0]        tx_data;
   logic [8*RB-1:0]   ctrl_regs;
   logic [8*NS-1:0]   status_in = '0;
   logic              wr_strobe;
   logic [7:0]        wr_index;
   logic              busy;

   int checks = 0, passes = 0;
   int mctrl[RB];
   int mstat[NS];
   int mptr = 0;
   bit mfirst = 0;

   i2c_reg_map #(.NUM_REGS(NR), .RO_BASE(RB)) dut (
      .clk(clk), .rst(rst), .txn_start(txn_start), .txn_write(txn_write),
      .txn_stop(txn_stop), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_taken(tx_taken), .tx_data(tx_data), .ctrl_regs(ctrl_regs),
      .status_in(status_in), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int inc(input int p);
      return (p >= NR - 1) ? 0 : p + 1;
   endfunction

   function automatic int mread(input int p);
      if (p < RB) return mctrl[p];
      if (p < NR) return mstat[p - RB];
      return 255;
   endfunction

   function automatic logic [63:0] ctrl_exp();
      logic [63:0] v = '0;
      for (int i = 0; i < RB; i++) v[8*i +: 8] = 8'(mctrl[i]);
      return v;
   endfunction

   task automatic drive_status();
      for (int i = 0; i < NS; i++) status_in[8*i +: 8] = 8'(mstat[i]);
   endtask

   task automatic start_txn(input bit wr);
      @(negedge clk); txn_start = 1; txn_write = wr;
      @(negedge clk); txn_start = 0;
      mfirst = wr;
      chk("busy_after_start", busy, 1);
      if (!wr) chk("rd_first_byte", tx_data, mread(mptr));
   endtask

   task automatic stop_txn();
      @(negedge clk); txn_stop = 1;
      @(negedge clk); txn_stop = 0;
      chk("busy_after_stop", busy, 0);
   endtask

   task automatic wbyte(input int b);
      bit exp_st;
      @(negedge clk); rx_valid = 1; rx_data = 8'(b);
      @(negedge clk); rx_valid = 0;
      exp_st = 0;
      if (mfirst) begin
         mptr = b; mfirst = 0;
      end else begin
         exp_st = (mptr < RB);
         if (exp_st) begin
            mctrl[mptr] = b;
            chk("wr_index", wr_index, mptr);
         end
         mptr = inc(mptr);
      end
      chk("wr_strobe", wr_strobe, exp_st);
      chk("ctrl_regs", ctrl_regs, ctrl_exp());
      @(negedge clk);
      chk("wr_strobe_one_cycle", wr_strobe, 0);
   endtask

   task automatic take();
      @(negedge clk); tx_taken = 1;
      @(negedge clk); tx_taken = 0;
      mptr = inc(mptr);
      chk("rd_next_byte", tx_data, mread(mptr));
   endtask

   initial begin
      int n, r, p;
      int held;
      repeat (3) @(negedge clk);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_ctrl", ctrl_regs, 0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_index", wr_index, 0);
      chk("rst_busy", busy, 0);
      rst = 0;

      for (int i = 0; i < NS; i++) mstat[i] = $urandom_range(0, 255);
      drive_status();

      // Pointer 2, two data bytes, then read back from ptr 4.
      start_txn(1); wbyte(8'h02); wbyte(8'hA5); wbyte(8'h5A);
      chk("ptr_after_write", mptr, 4);
      start_txn(0); take(); stop_txn();

      // Writes to read-only space are discarded.
      start_txn(1); wbyte(8'h09); wbyte(8'h77); stop_txn();
      chk("ro_ptr", mptr, 10);

      // Wrap across end of map via repeated start.
      mstat[7] = 8'h33; drive_status();
      start_txn(1); wbyte(8'h0E);
      start_txn(0); take(); take(); stop_txn();

      // Out-of-range pointer reads fill then returns to 0.
      start_txn(1); wbyte(8'h40);
      start_txn(0); take(); stop_txn();

      // Status changes mid-read.
      mstat[0] = 8'h11; drive_status();
      start_txn(1); wbyte(8'h07);
      start_txn(0);
      status_in[7:0] = 8'h22;
      @(negedge clk); tx_taken = 1;
      @(negedge clk); tx_taken = 0;
      mptr = inc(mptr);
`ifdef REGMAP_STATUS_SNAPSHOT_EN
      chk("snapshot_status", tx_data, 8'h11);
`else
      chk("live_status", tx_data, 8'h22);
`endif
      mstat[0] = 8'h22;
      take(); stop_txn();

      // Byte with stop is still processed.
      start_txn(1); wbyte(8'h01);
      @(negedge clk); rx_valid = 1; rx_data = 8'hC3; txn_stop = 1;
      @(negedge clk); rx_valid = 0; txn_stop = 0;
      mctrl[1] = 8'hC3; mptr = 2;
      chk("stop_byte_strobe", wr_strobe, 1);
      chk("stop_byte_ctrl", ctrl_regs, ctrl_exp());
      chk("stop_byte_busy", busy, 0);

      // Start wins over a same-cycle byte.
      start_txn(1); wbyte(8'h05);
      @(negedge clk); rx_valid = 1; rx_data = 8'h99; txn_start = 1; txn_write = 1;
      @(negedge clk); rx_valid = 0; txn_start = 0;
      mfirst = 1;
      chk("start_drop_strobe", wr_strobe, 0);
      chk("start_drop_ctrl", ctrl_regs, ctrl_exp());
      wbyte(8'h03); wbyte(8'h6E); stop_txn();

      // Take with stop increments the pointer; tx_data holds.
      start_txn(0);
      held = mread(mptr);
      @(negedge clk); tx_taken = 1; txn_stop = 1;
      @(negedge clk); tx_taken = 0; txn_stop = 0;
      mptr = inc(mptr);
      chk("take_stop_busy", busy, 0);
      chk("take_stop_hold", tx_data, held);
      start_txn(0); stop_txn();

      // Reset during WDATA aborts everything.
      start_txn(1); wbyte(8'h02);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      for (int i = 0; i < RB; i++) mctrl[i] = 0;
      mptr = 0;
      chk("midrst_ctrl", ctrl_regs, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_strobe", wr_strobe, 0);
      @(negedge clk); rx_valid = 1; rx_data = 8'h44;
      @(negedge clk); rx_valid = 0;
      chk("idle_rx_strobe", wr_strobe, 0);
      chk("idle_rx_ctrl", ctrl_regs, 0);
      start_txn(0); take(); stop_txn();

      // Random transactions.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            start_txn(1);
            r = $urandom_range(0, 9);
            p = (r < 8) ? $urandom_range(0, 17) : ((r == 8) ? 8'h40 : 8'hFF);
            wbyte(p);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) wbyte($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
               start_txn(0);
               n = $urandom_range(0, 3);
               for (int j = 0; j < n; j++) take();
            end
            stop_txn();
         end else begin
            for (int i = 0; i < NS; i++) mstat[i] = $urandom_range(0, 255);
            drive_status();
            start_txn(0);
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) take();
            stop_txn();
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
